// File: rtl/ob_match.sv
// rtl/ob_match.sv - order-book head matcher with trade and reject channels (optional stats: OB_MATCH_STATS_EN)

package bcd_pkg;
  // Four packed BCD digits; plain unsigned compare orders valid BCD numerically.
  typedef logic [15:0] price_t;
endpackage

package ob_pkg;
  typedef logic [7:0]  uid_t;
  typedef logic [15:0] quantity_t;
  typedef struct packed {
    uid_t            uid;
    bcd_pkg::price_t price;
    quantity_t       quantity;
  } table_t;
endpackage

module ob_match
  import ob_pkg::*;
(
`ifdef OB_MATCH_STATS_EN
  output logic [31:0]     trade_cnt_r,
  output logic [31:0]     rej_cnt_r,
`endif
  input  logic            clk,
  input  logic            rst,
  input  logic            match_en,
  input  logic            bid_head_vld_r,
  input  logic            ask_head_vld_r,
  input  table_t          bid_head_r,
  input  table_t          ask_head_r,
  output logic            bid_head_pop,
  output logic            ask_head_pop,
  output logic            bid_head_upt,
  output logic            ask_head_upt,
  output table_t          bid_head_upt_tbl,
  output table_t          ask_head_upt_tbl,
  input  logic            bid_reject_vld_r,
  input  logic            ask_reject_vld_r,
  input  table_t          bid_reject_r,
  input  table_t          ask_reject_r,
  output logic            bid_reject_pop,
  output logic            ask_reject_pop,
  output logic            trade_vld,
  input  logic            trade_rdy,
  output uid_t            trade_bid_uid,
  output uid_t            trade_ask_uid,
  output bcd_pkg::price_t trade_price,
  output quantity_t       trade_qty,
  output logic            rej_vld,
  input  logic            rej_rdy,
  output logic            rej_is_ask,
  output table_t          rej_tbl,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, TRADE, SETTLE} state_t;

  state_t    r_state;
  table_t    r_bid;
  table_t    r_ask;
  quantity_t r_trade_qty;
  logic      r_ask_rej_pop_d;
  logic      r_bid_rej_pop_d;

  logic      w_cross;
  logic      w_trade_hs;
  logic      w_bid_gt;
  logic      w_ask_gt;
  quantity_t w_bid_rem;
  quantity_t w_ask_rem;
  logic      w_zero_upt;
  logic      w_ask_rej_av;
  logic      w_bid_rej_av;
  logic      w_rej_vld;
  logic      w_rej_hs;

  assign w_cross = match_en & bid_head_vld_r & ask_head_vld_r &
                   (bid_head_r.price >= ask_head_r.price);

  // Match FSM: snapshot both heads on entry to TRADE, hold until handshake, settle one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_bid       <= '0;
      r_ask       <= '0;
      r_trade_qty <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_cross) begin
            r_state     <= TRADE;
            r_bid       <= bid_head_r;
            r_ask       <= ask_head_r;
            r_trade_qty <= (bid_head_r.quantity < ask_head_r.quantity) ?
                           bid_head_r.quantity : ask_head_r.quantity;
          end
        end
        TRADE: begin
          if (trade_rdy) r_state <= SETTLE;
        end
        SETTLE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign trade_vld     = (r_state == TRADE);
  assign trade_bid_uid = r_bid.uid;
  assign trade_ask_uid = r_ask.uid;
  assign trade_price   = r_ask.price;
  assign trade_qty     = r_trade_qty;

  // Head actions fire only in the handshake cycle; the larger side is updated, the rest popped.
  assign w_trade_hs = (r_state == TRADE) & trade_rdy;
  assign w_bid_gt   = r_bid.quantity > r_ask.quantity;
  assign w_ask_gt   = r_ask.quantity > r_bid.quantity;
  assign w_bid_rem  = r_bid.quantity - r_trade_qty;
  assign w_ask_rem  = r_ask.quantity - r_trade_qty;

  assign bid_head_pop = w_trade_hs & ~w_bid_gt;
  assign ask_head_pop = w_trade_hs & ~w_ask_gt;
  assign bid_head_upt = w_trade_hs & w_bid_gt;
  assign ask_head_upt = w_trade_hs & w_ask_gt;

  assign bid_head_upt_tbl = {r_bid.uid, r_bid.price, w_bid_rem};
  assign ask_head_upt_tbl = {r_ask.uid, r_ask.price, w_ask_rem};

  // An update leaving zero quantity would mean the min() selection is broken.
  assign w_zero_upt = (bid_head_upt & (w_bid_rem == '0)) | (ask_head_upt & (w_ask_rem == '0));

  // Flags impossible head actions: zero-quantity update, or pop and update on one table.
  a_head_action_ok: assert property (@(posedge clk) disable iff (!rst)
    !w_zero_upt && !(bid_head_pop && bid_head_upt) && !(ask_head_pop && ask_head_upt));

  // The reject flags are registered in the tables, so mask a side for one cycle after its pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ask_rej_pop_d <= 1'b0;
      r_bid_rej_pop_d <= 1'b0;
    end else begin
      r_ask_rej_pop_d <= ask_reject_pop;
      r_bid_rej_pop_d <= bid_reject_pop;
    end
  end

  assign w_ask_rej_av = ask_reject_vld_r & ~r_ask_rej_pop_d;
  assign w_bid_rej_av = bid_reject_vld_r & ~r_bid_rej_pop_d;
  assign w_rej_vld    = rst & (w_ask_rej_av | w_bid_rej_av);
  assign w_rej_hs     = w_rej_vld & rej_rdy;

  assign rej_vld        = w_rej_vld;
  assign rej_is_ask     = w_ask_rej_av;
  assign rej_tbl        = w_ask_rej_av ? ask_reject_r : bid_reject_r;
  assign ask_reject_pop = w_rej_hs & w_ask_rej_av;
  assign bid_reject_pop = w_rej_hs & ~w_ask_rej_av & w_bid_rej_av;

  assign busy = rst & ((r_state != IDLE) | w_cross);

`ifdef OB_MATCH_STATS_EN
  // Wrapping handshake counters for trades and rejects.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trade_cnt_r <= '0;
      rej_cnt_r   <= '0;
    end else begin
      if (w_trade_hs) trade_cnt_r <= trade_cnt_r + 32'd1;
      if (w_rej_hs)   rej_cnt_r   <= rej_cnt_r + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ob_match.sv
// tb/tb_ob_match.sv - directed self-checking bench for ob_match

module tb_ob_match;
  import ob_pkg::*;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            match_en = 1'b0;
  logic            bid_head_vld_r = 1'b0;
  logic            ask_head_vld_r = 1'b0;
  table_t          bid_head_r = '0;
  table_t          ask_head_r = '0;
  logic            bid_head_pop, ask_head_pop, bid_head_upt, ask_head_upt;
  table_t          bid_head_upt_tbl, ask_head_upt_tbl;
  logic            bid_reject_vld_r = 1'b0;
  logic            ask_reject_vld_r = 1'b0;
  table_t          bid_reject_r = '0;
  table_t          ask_reject_r = '0;
  logic            bid_reject_pop, ask_reject_pop;
  logic            trade_vld;
  logic            trade_rdy = 1'b0;
  uid_t            trade_bid_uid, trade_ask_uid;
  bcd_pkg::price_t trade_price;
  quantity_t       trade_qty;
  logic            rej_vld;
  logic            rej_rdy = 1'b0;
  logic            rej_is_ask;
  table_t          rej_tbl;
  logic            busy;
`ifdef OB_MATCH_STATS_EN
  logic [31:0]     trade_cnt_r, rej_cnt_r;
`endif

  int checks = 0;
  int errors = 0;

  ob_match dut (
`ifdef OB_MATCH_STATS_EN
    .trade_cnt_r(trade_cnt_r),
    .rej_cnt_r(rej_cnt_r),
`endif
    .clk(clk), .rst(rst), .match_en(match_en),
    .bid_head_vld_r(bid_head_vld_r), .ask_head_vld_r(ask_head_vld_r),
    .bid_head_r(bid_head_r), .ask_head_r(ask_head_r),
    .bid_head_pop(bid_head_pop), .ask_head_pop(ask_head_pop),
    .bid_head_upt(bid_head_upt), .ask_head_upt(ask_head_upt),
    .bid_head_upt_tbl(bid_head_upt_tbl), .ask_head_upt_tbl(ask_head_upt_tbl),
    .bid_reject_vld_r(bid_reject_vld_r), .ask_reject_vld_r(ask_reject_vld_r),
    .bid_reject_r(bid_reject_r), .ask_reject_r(ask_reject_r),
    .bid_reject_pop(bid_reject_pop), .ask_reject_pop(ask_reject_pop),
    .trade_vld(trade_vld), .trade_rdy(trade_rdy),
    .trade_bid_uid(trade_bid_uid), .trade_ask_uid(trade_ask_uid),
    .trade_price(trade_price), .trade_qty(trade_qty),
    .rej_vld(rej_vld), .rej_rdy(rej_rdy), .rej_is_ask(rej_is_ask),
    .rej_tbl(rej_tbl), .busy(busy)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] acts();
    return {bid_head_pop, ask_head_pop, bid_head_upt, ask_head_upt};
  endfunction

  task automatic clear_inputs();
    match_en = 0; bid_head_vld_r = 0; ask_head_vld_r = 0; trade_rdy = 0;
    bid_reject_vld_r = 0; ask_reject_vld_r = 0; rej_rdy = 0;
  endtask

  task automatic test_reset();
    bid_head_r = {8'd1, 16'h0100, 16'd5}; ask_head_r = {8'd2, 16'h0099, 16'd5};
    match_en = 1; bid_head_vld_r = 1; ask_head_vld_r = 1; trade_rdy = 1;
    ask_reject_vld_r = 1; bid_reject_vld_r = 1; rej_rdy = 1;
    #3 rst = 0;
    tick(); tick();
    checks++;
    if ({trade_vld, rej_vld, busy} !== 3'b000) begin
      errors++; $display("FAIL reset_vld: got %b expected 000", {trade_vld, rej_vld, busy});
    end
    checks++;
    if ({acts(), ask_reject_pop, bid_reject_pop} !== 6'b0) begin
      errors++; $display("FAIL reset_pops: got %b expected 000000", {acts(), ask_reject_pop, bid_reject_pop});
    end
    checks++;
    if ({trade_bid_uid, trade_ask_uid, trade_price, trade_qty} !== 48'h0) begin
      errors++; $display("FAIL reset_payload: got %h expected 0", {trade_bid_uid, trade_ask_uid, trade_price, trade_qty});
    end
    clear_inputs();
    rst = 1;
    tick();
  endtask

  task automatic test_full_fill();
    int busy_cycles = 0;
    bid_head_r = {8'd1, 16'h0100, 16'd5}; ask_head_r = {8'd2, 16'h0099, 16'd5};
    match_en = 1; bid_head_vld_r = 1; ask_head_vld_r = 1; trade_rdy = 1;
    #1;
    if (busy) busy_cycles++;
    checks++;
    if (trade_vld !== 1'b0) begin
      errors++; $display("FAIL full_eval_vld: got %b expected 0", trade_vld);
    end
    tick();
    if (busy) busy_cycles++;
    checks++;
    if ({trade_vld, trade_bid_uid, trade_ask_uid, trade_price, trade_qty} !== {1'b1, 8'd1, 8'd2, 16'h0099, 16'd5}) begin
      errors++; $display("FAIL full_trade: got %h expected %h",
        {trade_vld, trade_bid_uid, trade_ask_uid, trade_price, trade_qty}, {1'b1, 8'd1, 8'd2, 16'h0099, 16'd5});
    end
    checks++;
    if (acts() !== 4'b1100) begin
      errors++; $display("FAIL full_acts: got %b expected 1100", acts());
    end
    tick();
    bid_head_vld_r = 0; ask_head_vld_r = 0;
    #1;
    if (busy) busy_cycles++;
    checks++;
    if ({trade_vld, acts()} !== 5'b0) begin
      errors++; $display("FAIL full_settle: got %b expected 00000", {trade_vld, acts()});
    end
    tick();
    if (busy) busy_cycles++;
    checks++;
    if (busy_cycles !== 3) begin
      errors++; $display("FAIL full_busy_cycles: got %0d expected 3", busy_cycles);
    end
    clear_inputs();
  endtask

  task automatic test_partial_fill();
    table_t    bids [2] = '{{8'd3, 16'h0100, 16'd8}, {8'd7, 16'h0200, 16'd2}};
    table_t    asks [2] = '{{8'd4, 16'h0100, 16'd3}, {8'd8, 16'h0150, 16'd7}};
    logic [31:0] exp_pq [2] = '{{16'h0100, 16'd3}, {16'h0150, 16'd2}};
    logic [3:0]  exp_act [2] = '{4'b0110, 4'b1001};
    table_t    exp_upt [2] = '{{8'd3, 16'h0100, 16'd5}, {8'd8, 16'h0150, 16'd5}};
    for (int i = 0; i < 2; i++) begin
      bid_head_r = bids[i]; ask_head_r = asks[i];
      match_en = 1; bid_head_vld_r = 1; ask_head_vld_r = 1; trade_rdy = 1;
      tick();
      checks++;
      if ({trade_price, trade_qty} !== exp_pq[i]) begin
        errors++; $display("FAIL partial%0d_payload: got %h expected %h", i, {trade_price, trade_qty}, exp_pq[i]);
      end
      checks++;
      if (acts() !== exp_act[i]) begin
        errors++; $display("FAIL partial%0d_acts: got %b expected %b", i, acts(), exp_act[i]);
      end
      checks++;
      if ((i == 0 ? bid_head_upt_tbl : ask_head_upt_tbl) !== exp_upt[i]) begin
        errors++; $display("FAIL partial%0d_upt_tbl: got %h expected %h", i,
          (i == 0 ? bid_head_upt_tbl : ask_head_upt_tbl), exp_upt[i]);
      end
      tick();
      if (i == 0) begin bid_head_r = exp_upt[i]; ask_head_vld_r = 0; end
      else begin ask_head_r = exp_upt[i]; bid_head_vld_r = 0; end
      #1;
      checks++;
      if ({trade_vld, acts(), busy} !== 6'b000001) begin
        errors++; $display("FAIL partial%0d_settle: got %b expected 000001", i, {trade_vld, acts(), busy});
      end
      tick();
      checks++;
      if (busy !== 1'b0) begin
        errors++; $display("FAIL partial%0d_idle_busy: got %b expected 0", i, busy);
      end
      clear_inputs();
    end
  endtask

  task automatic test_no_cross();
    bid_head_r = {8'd1, 16'h0098, 16'd1}; ask_head_r = {8'd2, 16'h0099, 16'd1};
    match_en = 1; bid_head_vld_r = 1; ask_head_vld_r = 1; trade_rdy = 1;
    for (int i = 0; i < 12; i++) begin
      if (i == 6) begin bid_head_r.price = 16'h0120; match_en = 0; end
      if (i == 9) begin match_en = 1; bid_head_vld_r = 0; end
      #1;
      checks++;
      if ({busy, trade_vld, acts()} !== 6'b0) begin
        errors++; $display("FAIL no_cross_%0d: got %b expected 000000", i, {busy, trade_vld, acts()});
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_backpressure();
    bid_head_r = {8'd5, 16'h0105, 16'd4}; ask_head_r = {8'd6, 16'h0101, 16'd4};
    match_en = 1; bid_head_vld_r = 1; ask_head_vld_r = 1; trade_rdy = 0;
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({trade_vld, trade_bid_uid, trade_ask_uid, trade_price, trade_qty, acts()} !==
          {1'b1, 8'd5, 8'd6, 16'h0101, 16'd4, 4'b0000}) begin
        errors++; $display("FAIL stall_%0d: got %h expected %h", i,
          {trade_vld, trade_bid_uid, trade_ask_uid, trade_price, trade_qty, acts()},
          {1'b1, 8'd5, 8'd6, 16'h0101, 16'd4, 4'b0000});
      end
      tick();
    end
    trade_rdy = 1;
    #1;
    checks++;
    if ({trade_vld, acts()} !== 5'b11100) begin
      errors++; $display("FAIL stall_release: got %b expected 11100", {trade_vld, acts()});
    end
    tick();
    bid_head_vld_r = 0; ask_head_vld_r = 0;
    tick();
    clear_inputs();
  endtask

  task automatic test_rejects();
    ask_reject_r = {8'd9, 16'h0050, 16'd10}; bid_reject_r = {8'd10, 16'h0060, 16'd11};
    ask_reject_vld_r = 1; bid_reject_vld_r = 1; rej_rdy = 0;
    #1;
    checks++;
    if ({rej_vld, rej_is_ask, ask_reject_pop, bid_reject_pop} !== 4'b1100) begin
      errors++; $display("FAIL rej_hold: got %b expected 1100", {rej_vld, rej_is_ask, ask_reject_pop, bid_reject_pop});
    end
    rej_rdy = 1;
    #1;
    checks++;
    if ({rej_vld, rej_is_ask, ask_reject_pop, bid_reject_pop, rej_tbl} !== {4'b1110, 8'd9, 16'h0050, 16'd10}) begin
      errors++; $display("FAIL rej_ask_first: got %h expected %h",
        {rej_vld, rej_is_ask, ask_reject_pop, bid_reject_pop, rej_tbl}, {4'b1110, 8'd9, 16'h0050, 16'd10});
    end
    tick();
    checks++;
    if ({rej_vld, rej_is_ask, ask_reject_pop, bid_reject_pop, rej_tbl} !== {4'b1001, 8'd10, 16'h0060, 16'd11}) begin
      errors++; $display("FAIL rej_bid_second: got %h expected %h",
        {rej_vld, rej_is_ask, ask_reject_pop, bid_reject_pop, rej_tbl}, {4'b1001, 8'd10, 16'h0060, 16'd11});
    end
    tick();
    ask_reject_vld_r = 0;
    #1;
    checks++;
    if ({rej_vld, ask_reject_pop, bid_reject_pop} !== 3'b000) begin
      errors++; $display("FAIL rej_no_repeat: got %b expected 000", {rej_vld, ask_reject_pop, bid_reject_pop});
    end
    bid_reject_vld_r = 0;
    tick();
    clear_inputs();
  endtask

  task automatic test_reset_mid_trade();
    bid_head_r = {8'd11, 16'h0300, 16'd6}; ask_head_r = {8'd12, 16'h0250, 16'd9};
    match_en = 1; bid_head_vld_r = 1; ask_head_vld_r = 1; trade_rdy = 0;
    ask_reject_vld_r = 1; rej_rdy = 0;
    tick();
    checks++;
    if (trade_vld !== 1'b1) begin
      errors++; $display("FAIL rst_pre_trade: got %b expected 1", trade_vld);
    end
    trade_rdy = 1;
    rst = 0;
    #1;
    checks++;
    if ({trade_vld, busy, rej_vld, acts()} !== 7'b0) begin
      errors++; $display("FAIL rst_abort: got %b expected 0000000", {trade_vld, busy, rej_vld, acts()});
    end
    checks++;
    if ({trade_bid_uid, trade_ask_uid, trade_price, trade_qty} !== 48'h0) begin
      errors++; $display("FAIL rst_abort_payload: got %h expected 0", {trade_bid_uid, trade_ask_uid, trade_price, trade_qty});
    end
`ifdef OB_MATCH_STATS_EN
    checks++;
    if ({trade_cnt_r, rej_cnt_r} !== 64'h0) begin
      errors++; $display("FAIL rst_stats: got %h expected 0", {trade_cnt_r, rej_cnt_r});
    end
`endif
    tick();
    checks++;
    if ({trade_vld, acts()} !== 5'b0) begin
      errors++; $display("FAIL rst_hold: got %b expected 00000", {trade_vld, acts()});
    end
    rst = 1;
    #1;
    checks++;
    if ({trade_vld, acts(), busy} !== 6'b000001) begin
      errors++; $display("FAIL rst_first_idle: got %b expected 000001", {trade_vld, acts(), busy});
    end
    clear_inputs();
    tick(); tick();
  endtask

`ifdef OB_MATCH_STATS_EN
  task automatic test_stats();
    bid_head_r = {8'd1, 16'h0100, 16'd5}; ask_head_r = {8'd2, 16'h0099, 16'd5};
    match_en = 1; bid_head_vld_r = 1; ask_head_vld_r = 1; trade_rdy = 1;
    ask_reject_vld_r = 1; rej_rdy = 1;
    tick();
    ask_reject_vld_r = 0;
    tick();
    bid_head_vld_r = 0; ask_head_vld_r = 0;
    tick();
    checks++;
    if ({trade_cnt_r, rej_cnt_r} !== {32'd1, 32'd1}) begin
      errors++; $display("FAIL stats_count: got %h expected %h", {trade_cnt_r, rej_cnt_r}, {32'd1, 32'd1});
    end
    clear_inputs();
  endtask
`endif

  initial begin
    test_reset();
    test_full_fill();
    test_partial_fill();
    test_no_cross();
    test_backpressure();
    test_rejects();
    test_reset_mid_trade();
`ifdef OB_MATCH_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
